// File: rtl/motion_pkg.sv
// ============================================================================
// motion_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the object motion stage: FSM state encoding, screen
// geometry, coordinate widths and a signed saturation helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        UPDATE = 2'd2,
        DRAW   = 2'd3
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int OBJ_SIZE = 4;

    // Coordinate register widths (x covers 0..255, y covers 0..127)
    localparam int X_W = 8;
    localparam int Y_W = 7;

    // Clamp v into [-lim, +lim]
    function automatic int sat(input int v, input int lim);
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_integrator.sv
// ============================================================================
// axis_integrator
// ----------------------------------------------------------------------------
// Single-axis motion step, purely combinational. Adds the pending impulse to
// the velocity (saturating), optionally applies one step of friction, then
// integrates position and reflects off the 0 / MAX edges.
//
// Ports:
//   pos     in   W      current position (unsigned)
//   vel     in   V_W    current velocity (signed)
//   acc     in   V_W    accumulated impulse (signed)
//   fric    in   1      move velocity one step toward zero this update
//   new_pos out  W      updated position
//   new_vel out  V_W    updated velocity (negated on bounce)
//   bounce  out  1      an edge reflection happened on this axis
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_integrator
    import motion_pkg::*;
#(
    parameter int MAX  = 156,
    parameter int W    = 8,
    parameter int V_W  = 5,
    parameter int VMAX = 12
) (
    input  logic [W-1:0]          pos,
    input  logic signed [V_W-1:0] vel,
    input  logic signed [V_W-1:0] acc,
    input  logic                  fric,
    output logic [W-1:0]          new_pos,
    output logic signed [V_W-1:0] new_vel,
    output logic                  bounce
);

    // Two extra bits hold both the negative overshoot and up to 2*MAX
    localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);

    int                  v_sum;
    logic signed [W+1:0] v_ext;
    logic signed [W+1:0] nxt;
    logic signed [W+1:0] refl;

    always_comb begin
        v_sum = sat(int'(vel) + int'(acc), VMAX);
        if (fric && (v_sum > 0)) begin
            v_sum = v_sum - 1;
        end else if (fric && (v_sum < 0)) begin
            v_sum = v_sum + 1;
        end

        v_ext   = (W+2)'(v_sum);
        nxt     = $signed({2'b00, pos}) + v_ext;
        refl    = nxt;
        new_vel = V_W'(v_sum);
        bounce  = 1'b0;

        // Landing exactly on 0 or MAX is a legal position, not a bounce
        if (nxt < 0) begin
            refl    = -nxt;
            new_vel = V_W'(-v_sum);
            bounce  = 1'b1;
        end else if (nxt > MAX_S) begin
            refl    = MAX_S + MAX_S - nxt;
            new_vel = V_W'(-v_sum);
            bounce  = 1'b1;
        end

        new_pos = W'(refl);
    end

endmodule

`default_nettype wire

// File: rtl/object_motion.sv
// ============================================================================
// object_motion
// ----------------------------------------------------------------------------
// Per-frame motion stage for one square object. Each frame tick issues an
// erase request at the old position, updates velocity/position with edge
// bounce, then issues a draw request at the new position over valid/ready.
//
// Optional feature macro: FRICTION_EN
//   defined   -> every FRICTION_PERIOD-th update moves each velocity
//                component one step toward zero
//   undefined -> velocity changes only by impulse and bounce
//
// Ports:
//   clk          in   1    system clock
//   reset        in   1    asynchronous active-low reset
//   frame_tick   in   1    one-cycle frame pulse
//   push_valid   in   1    impulse strobe
//   push_dx/dy   in   V_W  signed impulse
//   draw_ready   in   1    drawing stage accepts the request
//   draw_valid   out  1    request pending
//   draw_x       out  8    request x (top-left)
//   draw_y       out  7    request y (top-left)
//   draw_erase   out  1    1 = background, 0 = object
//   busy         out  1    FSM not idle
//   overrun      out  1    sticky: tick dropped while one was pending
//   bounce_count out  8    wrapping bounce counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module object_motion
    import motion_pkg::*;
#(
    parameter int SCREEN_W        = 160,
    parameter int SCREEN_H        = 120,
    parameter int OBJ_SIZE        = 4,
    parameter int V_W             = 5,
    parameter int VMAX            = 12,
    parameter int INIT_X          = 78,
    parameter int INIT_Y          = 58,
    parameter int FRICTION_PERIOD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  push_valid,
    input  logic signed [V_W-1:0] push_dx,
    input  logic signed [V_W-1:0] push_dy,
    input  logic                  draw_ready,
    output logic                  draw_valid,
    output logic [X_W-1:0]        draw_x,
    output logic [Y_W-1:0]        draw_y,
    output logic                  draw_erase,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            bounce_count
);

    state_t                state;
    state_t                state_next;
    logic [X_W-1:0]        pos_x;
    logic [Y_W-1:0]        pos_y;
    logic signed [V_W-1:0] vel_x;
    logic signed [V_W-1:0] vel_y;
    logic signed [V_W-1:0] acc_x;
    logic signed [V_W-1:0] acc_y;
    logic                  tick_pending;

    logic [X_W-1:0]        new_x;
    logic [Y_W-1:0]        new_y;
    logic signed [V_W-1:0] new_vx;
    logic signed [V_W-1:0] new_vy;
    logic                  bounce_x;
    logic                  bounce_y;
    logic                  fric_now;

    // ------------------------------------------------------------------
    // Friction scheduling
    // ------------------------------------------------------------------
`ifdef FRICTION_EN
    logic [$clog2(FRICTION_PERIOD+1)-1:0] fric_cnt;

    assign fric_now = (state == UPDATE) && (int'(fric_cnt) == FRICTION_PERIOD - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fric_cnt <= '0;
        end else if (state == UPDATE) begin
            fric_cnt <= fric_now ? '0 : fric_cnt + 1'b1;
        end
    end
`else
    assign fric_now = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-axis arithmetic
    // ------------------------------------------------------------------
    axis_integrator #(
        .MAX  (SCREEN_W - OBJ_SIZE),
        .W    (X_W),
        .V_W  (V_W),
        .VMAX (VMAX)
    ) u_axis_x (
        .pos     (pos_x),
        .vel     (vel_x),
        .acc     (acc_x),
        .fric    (fric_now),
        .new_pos (new_x),
        .new_vel (new_vx),
        .bounce  (bounce_x)
    );

    axis_integrator #(
        .MAX  (SCREEN_H - OBJ_SIZE),
        .W    (Y_W),
        .V_W  (V_W),
        .VMAX (VMAX)
    ) u_axis_y (
        .pos     (pos_y),
        .vel     (vel_y),
        .acc     (acc_y),
        .fric    (fric_now),
        .new_pos (new_y),
        .new_vel (new_vy),
        .bounce  (bounce_y)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and request outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        draw_valid = 1'b0;
        draw_erase = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        case (state)
            IDLE: begin
                if (frame_tick || tick_pending) begin
                    state_next = ERASE;
                end
            end
            ERASE: begin
                draw_valid = 1'b1;
                draw_erase = 1'b1;
                draw_x     = pos_x;
                draw_y     = pos_y;
                if (draw_ready) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = DRAW;
            end
            DRAW: begin
                draw_valid = 1'b1;
                draw_x     = pos_x;
                draw_y     = pos_y;
                if (draw_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Tick bookkeeping. In IDLE a pending tick is consumed, and a tick
    // landing in that same cycle becomes the next pending one. Outside
    // IDLE a second waiting tick is dropped and flagged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_pending <= 1'b0;
            overrun      <= 1'b0;
        end else if (state == IDLE) begin
            if (tick_pending) begin
                tick_pending <= frame_tick;
            end
        end else if (frame_tick) begin
            if (tick_pending) begin
                overrun <= 1'b1;
            end else begin
                tick_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Impulse accumulation; a push during UPDATE seeds the freshly
    // cleared accumulator so it applies on the following frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_x <= '0;
            acc_y <= '0;
        end else if (state == UPDATE) begin
            acc_x <= push_valid ? V_W'(sat(int'(push_dx), VMAX)) : '0;
            acc_y <= push_valid ? V_W'(sat(int'(push_dy), VMAX)) : '0;
        end else if (push_valid) begin
            acc_x <= V_W'(sat(int'(acc_x) + int'(push_dx), VMAX));
            acc_y <= V_W'(sat(int'(acc_y) + int'(push_dy), VMAX));
        end
    end

    // ------------------------------------------------------------------
    // Motion state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_x        <= X_W'(INIT_X);
            pos_y        <= Y_W'(INIT_Y);
            vel_x        <= '0;
            vel_y        <= '0;
            bounce_count <= '0;
        end else if (state == UPDATE) begin
            pos_x        <= new_x;
            pos_y        <= new_y;
            vel_x        <= new_vx;
            vel_y        <= new_vy;
            bounce_count <= bounce_count + {7'd0, bounce_x} + {7'd0, bounce_y};
        end
    end

endmodule

`default_nettype wire
